// File: rtl/io_data_mem_pkg.sv
// Shared constants and region decode type for the HACK data memory.
package io_data_mem_pkg;

  // Default placement of the memory-mapped blocks
  localparam int unsigned DefOregBase = 32'h7000;
  localparam int unsigned DefIregBase = 32'h7400;
  localparam int unsigned DefCtrlBase = 32'h7800;

  // Offsets inside the control block
  localparam int unsigned CtrlStat = 0;
  localparam int unsigned CtrlMask = 1;
  localparam int unsigned CtrlTick = 2;

  // Address region, shared by the write decode and the readback mux
  typedef enum logic [2:0] {
    RegRam,
    RegOreg,
    RegIreg,
    RegStat,
    RegMask,
    RegTick,
    RegNone
  } region_e;

endpackage

// File: rtl/io_data_mem_if.sv
// CPU data-port bus: strobes, address, write data and registered read return.
interface io_data_mem_if #(
  parameter int unsigned AW = 15,
  parameter int unsigned DW = 16
);
  logic          we;
  logic          re;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          rd_valid;

  modport master (output we, re, addr, data_in, input data_out, rd_valid);
  modport slave  (input we, re, addr, data_in, output data_out, rd_valid);
endinterface

// File: rtl/ireg_sync.sv
// One board input channel: 2-flop synchroniser, previous-value register, change flag.
module ireg_sync #(
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          change_o
);

  logic [DW-1:0] sync1_q, sync2_q, prev_q;

  // Synchroniser chain plus one-stage history for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign data_o   = sync2_q;
  assign change_o = (sync2_q != prev_q);

endmodule

// File: rtl/io_data_mem.sv
// HACK data memory: RAM, output/input registers, sticky input-change flags,
// interrupt mask and free-running tick, all read through a one-cycle path.
module io_data_mem
  import io_data_mem_pkg::*;
#(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 16,
  parameter int unsigned RAM_AW    = 14,
  parameter int unsigned N_OREG    = 4,
  parameter int unsigned N_IREG    = 4,
  parameter int unsigned OREG_BASE = DefOregBase,
  parameter int unsigned IREG_BASE = DefIregBase,
  parameter int unsigned CTRL_BASE = DefCtrlBase
) (
  input  logic                         clk50m,
  input  logic                         rst,
  io_data_mem_if.slave                 bus,
  output logic [N_OREG-1:0][DW-1:0]    oreg,
  input  logic [N_IREG-1:0][DW-1:0]    ireg,
  output logic                         irq
);

  localparam int unsigned OIW = (N_OREG > 1) ? $clog2(N_OREG) : 1;
  localparam int unsigned IIW = (N_IREG > 1) ? $clog2(N_IREG) : 1;

  logic [31:0]               a32;
  region_e                   region;
  logic [OIW-1:0]            oidx;
  logic [IIW-1:0]            iidx;

  logic [DW-1:0]             mem [2**RAM_AW];
  logic [DW-1:0]             ram_rdata_q;
  logic [DW-1:0]             reg_rdata, reg_rdata_q;
  region_e                   rd_region_q;
  logic                      rd_valid_q;

  logic [N_OREG-1:0][DW-1:0] oreg_q;
  logic [N_IREG-1:0]         mask_q, stat_q, stat_d, change, stat_clr, stat_set;
  logic [DW-1:0]             tick_q;
  logic [1:0]                arm_q;
  logic                      irq_q;
  logic [DW-1:0]             sync_val [N_IREG];

  assign a32 = 32'(bus.addr);

  // Address decode into a region plus index within that region
  always_comb begin
    region = RegNone;
    oidx   = '0;
    iidx   = '0;
    if (a32 < (32'd1 << RAM_AW)) begin
      region = RegRam;
    end else if (a32 >= OREG_BASE && a32 < OREG_BASE + N_OREG) begin
      region = RegOreg;
      oidx   = OIW'(a32 - OREG_BASE);
    end else if (a32 >= IREG_BASE && a32 < IREG_BASE + N_IREG) begin
      region = RegIreg;
      iidx   = IIW'(a32 - IREG_BASE);
    end else if (a32 == CTRL_BASE + CtrlStat) begin
      region = RegStat;
    end else if (a32 == CTRL_BASE + CtrlMask) begin
      region = RegMask;
    end else if (a32 == CTRL_BASE + CtrlTick) begin
      region = RegTick;
    end
  end

  for (genvar i = 0; i < N_IREG; i++) begin : g_ireg
    ireg_sync #(.DW(DW)) u_sync (
      .clk_i   (clk50m),
      .rst_i   (rst),
      .data_i  (ireg[i]),
      .data_o  (sync_val[i]),
      .change_o(change[i])
    );
  end

  // RAM with read-first behaviour; no reset so it maps onto block RAM
  always_ff @(posedge clk50m) begin
    if (bus.we && region == RegRam) mem[bus.addr[RAM_AW-1:0]] <= bus.data_in;
    if (bus.re) ram_rdata_q <= mem[bus.addr[RAM_AW-1:0]];
  end

  // Register readback selected by region; RAM and unmapped give zero here
  always_comb begin
    reg_rdata = '0;
    unique case (region)
      RegOreg: reg_rdata = oreg_q[oidx];
      RegIreg: reg_rdata = sync_val[iidx];
      RegStat: reg_rdata = DW'(stat_q);
      RegMask: reg_rdata = DW'(mask_q);
      RegTick: reg_rdata = tick_q;
      default: reg_rdata = '0;
    endcase
  end

  // Read pipeline stage: region and register data captured with the RAM read
  always_ff @(posedge clk50m) begin
    if (rst) begin
      rd_valid_q  <= 1'b0;
      rd_region_q <= RegNone;
      reg_rdata_q <= '0;
    end else begin
      rd_valid_q <= bus.re;
      if (bus.re) begin
        rd_region_q <= region;
        reg_rdata_q <= reg_rdata;
      end
    end
  end

  assign bus.data_out = (rd_region_q == RegRam) ? ram_rdata_q : reg_rdata_q;
  assign bus.rd_valid = rd_valid_q;

  // Sticky change flags: a new change beats a simultaneous write-1-to-clear
  always_comb begin
    stat_clr = (bus.we && region == RegStat) ? bus.data_in[N_IREG-1:0] : '0;
    stat_set = (arm_q == 2'd3) ? change : '0;
    stat_d   = (stat_q & ~stat_clr) | stat_set;
  end

  // Control state: output registers, mask, flags, tick, arm counter, irq
  always_ff @(posedge clk50m) begin
    if (rst) begin
      oreg_q <= '0;
      mask_q <= '0;
      stat_q <= '0;
      tick_q <= '0;
      arm_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (bus.we && region == RegOreg) oreg_q[oidx] <= bus.data_in;
      if (bus.we && region == RegMask) mask_q <= bus.data_in[N_IREG-1:0];
      tick_q <= (bus.we && region == RegTick) ? bus.data_in : tick_q + DW'(1);
      // Hold off detection until the synchroniser has flushed reset zeros
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
      stat_q <= stat_d;
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign oreg = oreg_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_io_data_mem.sv
// Directed plus randomised bench for io_data_mem with a per-edge reference model.
module tb_io_data_mem;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int NO = 4;
  localparam int NI = 4;

  logic                  clk50m = 1'b0;
  logic                  rst;
  logic [NO-1:0][DW-1:0] oreg;
  logic [NI-1:0][DW-1:0] ireg;
  logic                  irq;

  io_data_mem_if #(.AW(AW), .DW(DW)) bus_if ();

  io_data_mem #(.AW(AW), .DW(DW), .N_OREG(NO), .N_IREG(NI)) dut (
    .clk50m(clk50m),
    .rst   (rst),
    .bus   (bus_if),
    .oreg  (oreg),
    .ireg  (ireg),
    .irq   (irq)
  );

  always #10 clk50m = ~clk50m;

  int checks   = 0;
  int failures = 0;

  // Reference model state, expressed per clock edge number
  logic [15:0]           ram_m [int];
  logic [NO-1:0][15:0]   oreg_m;
  logic [NI-1:0]         mask_m, stat_m;
  logic [15:0]           tick_load;
  int                    tick_edge;
  logic [63:0]           hist [0:4095];
  int                    cyc = 0;
  int                    rel = 0;
  logic [15:0]           dout_m;
  logic                  valid_m, irq_m;
  logic [14:0]           ram_set [8] = '{15'h0000, 15'h0001, 15'h1234, 15'h3FFF,
                                        15'h0100, 15'h2AAA, 15'h1555, 15'h3000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [14:0] a, input logic [15:0] d);
    bus_if.we      = w;
    bus_if.re      = r;
    bus_if.addr    = a;
    bus_if.data_in = d;
  endtask

  // Value a read sampled at edge e must return (state before that edge)
  function automatic logic [15:0] mread(input logic [14:0] a, input int e);
    int ai = int'(a);
    if (ai < 16384) return ram_m[ai];
    if (ai >= 32'h7000 && ai < 32'h7000 + NO) return oreg_m[ai - 32'h7000];
    if (ai >= 32'h7400 && ai < 32'h7400 + NI) begin
      if (e - 2 < rel) return 16'h0;
      return hist[e-2][16*(ai-32'h7400) +: 16];
    end
    if (ai == 32'h7800) return 16'(stat_m);
    if (ai == 32'h7801) return 16'(mask_m);
    if (ai == 32'h7802) return 16'(32'(tick_load) + (e - 1 - tick_edge));
    return 16'h0;
  endfunction

  // Advance one edge: update the model, then compare all outputs after the edge
  task automatic step();
    int            e = cyc + 1;
    int            ai;
    logic [NI-1:0] sets, clr;
    hist[e] = rst ? 64'h0 : ireg;
    if (rst) begin
      valid_m = 1'b0; dout_m = '0; irq_m = 1'b0; oreg_m = '0;
      mask_m = '0; stat_m = '0; tick_load = '0; tick_edge = e; rel = e + 1;
    end else begin
      irq_m   = |(stat_m & mask_m);
      valid_m = bus_if.re;
      if (bus_if.re) dout_m = mread(bus_if.addr, e);
      sets = '0;
      if (e >= rel + 3)
        for (int i = 0; i < NI; i++) sets[i] = (hist[e-2][16*i +: 16] != hist[e-3][16*i +: 16]);
      clr = '0;
      if (bus_if.we) begin
        ai = int'(bus_if.addr);
        if (ai < 16384) ram_m[ai] = bus_if.data_in;
        else if (ai >= 32'h7000 && ai < 32'h7000 + NO) oreg_m[ai - 32'h7000] = bus_if.data_in;
        else if (ai == 32'h7800) clr = bus_if.data_in[NI-1:0];
        else if (ai == 32'h7801) mask_m = bus_if.data_in[NI-1:0];
        else if (ai == 32'h7802) begin tick_load = bus_if.data_in; tick_edge = e; end
      end
      stat_m = (stat_m & ~clr) | sets;
    end
    @(posedge clk50m);
    #1;
    cyc = e;
    chk("rd_valid", 64'(bus_if.rd_valid), 64'(valid_m));
    chk("data_out", 64'(bus_if.data_out), 64'(dout_m));
    chk("irq", 64'(irq), 64'(irq_m));
    chk("oreg", oreg, oreg_m);
  endtask

  initial begin
    logic [14:0] a;
    int          k;
    rst  = 1'b1;
    ireg = '0;
    ireg[0] = 16'h00FF;
    drive(0, 0, 15'h0, 16'h0);

    // Reset with a nonzero input held through it
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    drive(0, 1, 15'h7800, 16'h0); step();
    chk("stat_after_reset", 64'(bus_if.data_out), 64'h0);
    chk("irq_after_reset", 64'(irq), 64'h0);
    chk("oreg_after_reset", oreg, 64'h0);
    drive(0, 1, 15'h7802, 16'h0); step();
    chk("tick_after_reset", 64'(bus_if.data_out), 64'd6);

    // RAM write, read-back, same-cycle read/write
    drive(1, 0, 15'h1234, 16'hBEEF); step();
    drive(0, 1, 15'h1234, 16'h0); step();
    chk("ram_read", 64'(bus_if.data_out), 64'hBEEF);
    chk("ram_rd_valid", 64'(bus_if.rd_valid), 64'h1);
    drive(1, 1, 15'h1234, 16'h0001); step();
    chk("ram_rw_same", 64'(bus_if.data_out), 64'hBEEF);
    drive(0, 1, 15'h1234, 16'h0); step();
    chk("ram_after_rw", 64'(bus_if.data_out), 64'h0001);

    // Output register and unmapped read, then hold with re low
    drive(1, 0, 15'h7002, 16'hA5A5); step();
    chk("oreg2", 64'(oreg[2]), 64'hA5A5);
    drive(0, 1, 15'h7004, 16'h0); step();
    chk("unmapped", 64'(bus_if.data_out), 64'h0);
    chk("unmapped_valid", 64'(bus_if.rd_valid), 64'h1);
    drive(0, 1, 15'h7002, 16'h0); step();
    chk("oreg2_read", 64'(bus_if.data_out), 64'hA5A5);
    drive(0, 0, 15'h0, 16'h0); step();
    chk("hold_valid", 64'(bus_if.rd_valid), 64'h0);
    chk("hold_data", 64'(bus_if.data_out), 64'hA5A5);

    // Input change to interrupt, then W1C
    drive(1, 0, 15'h7801, 16'h0002); step();
    drive(0, 0, 15'h0, 16'h0);
    ireg[1] = 16'h0010;
    step(); step(); step();
    chk("irq_before_t3", 64'(irq), 64'h0);
    drive(0, 1, 15'h7800, 16'h0); step();
    chk("stat_set", 64'(bus_if.data_out), 64'h2);
    chk("irq_t3", 64'(irq), 64'h1);
    drive(1, 0, 15'h7800, 16'h0002); step();
    drive(0, 0, 15'h0, 16'h0); step();
    chk("irq_cleared", 64'(irq), 64'h0);

    // Clear coinciding with a fresh change: set wins
    ireg[1] = 16'h0030;
    step(); step(); step();
    ireg[1] = 16'h0040;
    step(); step();
    drive(1, 0, 15'h7800, 16'h0002); step();
    drive(0, 1, 15'h7800, 16'h0); step();
    chk("stat_set_wins", 64'(bus_if.data_out), 64'h2);
    chk("irq_set_wins", 64'(irq), 64'h1);
    drive(1, 0, 15'h7800, 16'h000F); step();
    drive(1, 0, 15'h7801, 16'h0000); step();

    // Tick load and wrap
    drive(1, 0, 15'h7802, 16'hFFFE); step();
    drive(0, 1, 15'h7802, 16'h0); step();
    chk("tick0", 64'(bus_if.data_out), 64'hFFFE);
    step(); chk("tick1", 64'(bus_if.data_out), 64'hFFFF);
    step(); chk("tick2", 64'(bus_if.data_out), 64'h0000);
    step(); chk("tick3", 64'(bus_if.data_out), 64'h0001);

    // Randomised traffic against the model
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, ram_set[i], 16'($urandom)); step();
    end
    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 15));
      if (k < 5)       a = ram_set[$urandom_range(0, 7)];
      else if (k < 7)  a = 15'(32'h7000 + $urandom_range(0, 5));
      else if (k == 7) a = 15'(32'h7400 + $urandom_range(0, 4));
      else if (k == 8) a = 15'(32'h7800 + $urandom_range(0, 3));
      else if (k == 9) a = 15'h5000;
      else if (k == 10) a = 15'h7FFF;
      else             a = ram_set[$urandom_range(0, 7)];
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      if ($urandom_range(0, 7) == 0) ireg[$urandom_range(0, NI - 1)] = 16'($urandom);
      step();
    end

    // Reset in the middle of back-to-back reads
    drive(0, 1, 15'h1234, 16'h0);
    step(); step();
    rst = 1'b1; step();
    chk("midrst_valid", 64'(bus_if.rd_valid), 64'h0);
    chk("midrst_data", 64'(bus_if.data_out), 64'h0);
    chk("midrst_oreg", oreg, 64'h0);
    rst = 1'b0;
    repeat (3) step();
    chk("after_rst_valid", 64'(bus_if.rd_valid), 64'h1);
    drive(0, 1, 15'h7800, 16'h0); step();
    chk("after_rst_stat", 64'(bus_if.data_out), 64'h0);
    repeat (4) step();
    drive(0, 0, 15'h0, 16'h0); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
